// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the byte-level I2C master.
//   - cmd and status bit positions
//   - byte FSM state encoding, quarter-phase encoding, bit-slot kind
//   - next_stage(): picks the next stage of a command from its remaining bits
package i2c_pkg;

   // cmd register bit positions
   localparam int CMD_START = 7;
   localparam int CMD_STOP  = 6;
   localparam int CMD_READ  = 5;
   localparam int CMD_WRITE = 4;
   localparam int CMD_ACK   = 3;

   // status register bit positions
   localparam int ST_BUSY     = 7;
   localparam int ST_NACK     = 6;
   localparam int ST_DONE     = 5;
   localparam int ST_BUS_BUSY = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WRITE,
      S_READ,
      S_ACK,
      S_STOP
   } state_t;

   // Quarters of one SCL bit period
   typedef enum logic [1:0] {
      PH_A,
      PH_B,
      PH_C,
      PH_D
   } phase_t;

   // What the bit controller is currently sequencing
   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_START,
      SLOT_DATA,
      SLOT_STOP
   } slot_t;

   // Stages run in the fixed order START, WRITE/READ, STOP; unset ones are skipped.
   function automatic state_t next_stage(input logic start, input logic wr,
                                         input logic rd, input logic stop);
      if (start)     return S_START;
      else if (wr)   return S_WRITE;
      else if (rd)   return S_READ;
      else if (stop) return S_STOP;
      else           return S_IDLE;
   endfunction

endpackage

// File: rtl/i2c_bit_ctrl.sv
// i2c_bit_ctrl: quarter-tick divider, SCL stretch hold, A..D phase sequencing
// and open-drain line drive for one bit slot at a time.
// Ports:
//   clk, rst_   system clock / async active-low reset
//   slot        slot_t kind being sequenced (SLOT_IDLE stops and clears counters)
//   tx_bit      SDA level for a data slot (1 = release)
//   hold_scl    keep SCL low while idle / in START phase A (bus owned between START and STOP)
//   scl_i       SCL line level, low during phase B means the target is stretching
//   scl_oen     0 = pull SCL low, 1 = release
//   sda_oen     0 = pull SDA low, 1 = release
//   sample      one-clk strobe at the end of phase C
//   bit_end     one-clk strobe at the end of phase D (slot complete)
module i2c_bit_ctrl #(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic [1:0] slot,
   input  logic       tx_bit,
   input  logic       hold_scl,
   input  logic       scl_i,
   output logic       scl_oen,
   output logic       sda_oen,
   output logic       sample,
   output logic       bit_end
);
   import i2c_pkg::*;

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [QW-1:0] qcnt;
   phase_t        phase;
   logic          active;
   logic          stretch;
   logic          q_wrap;

   assign active  = (slot != SLOT_IDLE);
   // SCL is released in phase B; a low line there is the target holding the clock.
   assign stretch = (phase == PH_B) && !scl_i;
   assign q_wrap  = active && !stretch && (qcnt == QW'(CLK_DIV - 1));
   assign sample  = q_wrap && (phase == PH_C);
   assign bit_end = q_wrap && (phase == PH_D);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         qcnt  <= '0;
         phase <= PH_A;
      end else if (!active) begin
         qcnt  <= '0;
         phase <= PH_A;
      end else if (!stretch) begin
         if (q_wrap) begin
            qcnt  <= '0;
            phase <= phase_t'(phase + 2'd1);   // D wraps to A of the next slot
         end else begin
            qcnt <= qcnt + 1'b1;
         end
      end
   end

   // NOTE: both outputs get a default before the case so no path leaves them
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      scl_oen = 1'b1;
      sda_oen = 1'b1;
      unique case (slot_t'(slot))
         SLOT_IDLE: scl_oen = ~hold_scl;
         SLOT_START: begin
            unique case (phase)
               PH_A: scl_oen = ~hold_scl;   // low only for a repeated START
               PH_B: ;
               PH_C: sda_oen = 1'b0;        // SDA falls while SCL high
               PH_D: begin
                  scl_oen = 1'b0;
                  sda_oen = 1'b0;
               end
            endcase
         end
         SLOT_DATA: begin
            scl_oen = (phase == PH_B) || (phase == PH_C);
            sda_oen = tx_bit;
         end
         SLOT_STOP: begin
            unique case (phase)
               PH_A: begin
                  scl_oen = 1'b0;
                  sda_oen = 1'b0;
               end
               PH_B: sda_oen = 1'b0;
               PH_C: ;                      // SDA rises while SCL high
               PH_D: ;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/i2c_fsm_master.sv
// i2c_fsm_master: byte-level I2C master driven by START/STOP/READ/WRITE commands.
// Ports:
//   clk, rst_      system clock / async active-low reset
//   cmd, cmd_valid command strobe, accepted when not busy
//   din            byte to send, captured at accept
//   dout           last byte received, updated at the end of a READ's ACK slot
//   status         [7]busy [6]nack [5]done pulse [0]bus_busy
//   scl_i/o/oen    SCL open-drain (o tied 0, oen 0 = pull low)
//   sda_i/o/oen    SDA open-drain (o tied 0, oen 0 = pull low)
module i2c_fsm_master #(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic [7:0] cmd,
   input  logic       cmd_valid,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic [7:0] status,
   input  logic       scl_i,
   output logic       scl_o,
   output logic       scl_oen,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_oen
);
   import i2c_pkg::*;

   state_t     state, state_n;
   logic       accept, finish;
   logic       busy, done, nack, bus_busy;
   logic       stop_q, rd_q, wr_q, ack_q;
   logic [7:0] sh;
   logic [2:0] bit_cnt;
   slot_t      slot;
   logic       tx_bit, sample, bit_end;
   logic       cmd_unused;

   logic cmd_wr, cmd_rd;
   assign cmd_wr     = cmd[CMD_WRITE];
   assign cmd_rd     = cmd[CMD_READ] & ~cmd[CMD_WRITE];   // WRITE wins when both set
   assign cmd_unused = ^cmd[2:0];

   assign accept = cmd_valid && !busy;
   assign scl_o  = 1'b0;
   assign sda_o  = 1'b0;
   assign status = {busy, nack, done, 4'b0000, bus_busy};

   i2c_bit_ctrl #(.CLK_DIV(CLK_DIV)) u_bit (
      .clk      (clk),
      .rst_     (rst_),
      .slot     (slot),
      .tx_bit   (tx_bit),
      .hold_scl (bus_busy),
      .scl_i    (scl_i),
      .scl_oen  (scl_oen),
      .sda_oen  (sda_oen),
      .sample   (sample),
      .bit_end  (bit_end)
   );

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) state <= S_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      finish  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (accept)    state_n = next_stage(cmd[CMD_START], cmd_wr, cmd_rd, cmd[CMD_STOP]);
            else if (busy) finish  = 1'b1;   // empty command: done one cycle after accept
         end
         S_START: if (bit_end) state_n = next_stage(1'b0, wr_q, rd_q, stop_q);
         S_WRITE, S_READ: if (bit_end && bit_cnt == 3'd0) state_n = S_ACK;
         S_ACK:   if (bit_end) state_n = next_stage(1'b0, 1'b0, 1'b0, stop_q);
         S_STOP:  if (bit_end) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (state != S_IDLE && state_n == S_IDLE) finish = 1'b1;
   end

   // Slot kind and SDA level handed to the bit controller
   always_comb begin
      slot   = SLOT_IDLE;
      tx_bit = 1'b1;
      unique case (state)
         S_IDLE:  ;
         S_START: slot = SLOT_START;
         S_WRITE: begin
            slot   = SLOT_DATA;
            tx_bit = sh[7];
         end
         S_READ:  slot = SLOT_DATA;
         S_ACK: begin
            slot   = SLOT_DATA;
            tx_bit = rd_q ? ack_q : 1'b1;   // after WRITE the target owns SDA
         end
         S_STOP:  slot = SLOT_STOP;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         nack     <= 1'b0;
         bus_busy <= 1'b0;
         stop_q   <= 1'b0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         ack_q    <= 1'b0;
         sh       <= '0;
         bit_cnt  <= '0;
         dout     <= '0;
      end else begin
         done <= finish;
         if (finish) busy <= 1'b0;

         if (accept) begin
            busy    <= 1'b1;
            stop_q  <= cmd[CMD_STOP];
            rd_q    <= cmd_rd;
            wr_q    <= cmd_wr;
            ack_q   <= cmd[CMD_ACK];
            sh      <= din;
            bit_cnt <= 3'd7;
         end

         // Down-counter wraps 0 -> 7 on entering ACK, ready for the next byte
         if ((state == S_WRITE || state == S_READ) && bit_end)
            bit_cnt <= bit_cnt - 3'd1;

         if (state == S_WRITE && bit_end) sh <= {sh[6:0], 1'b0};
         if (state == S_READ && sample)   sh <= {sh[6:0], sda_i};

         if (state == S_ACK && sample && wr_q) nack <= sda_i;
         if (state == S_ACK && bit_end && rd_q) dout <= sh;

         if (state == S_START && sample) bus_busy <= 1'b1;
         if (state == S_STOP && sample)  bus_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2c_fsm_master.sv
// Self-checking bench for i2c_fsm_master: a bus monitor and a simple target
// model sit on the open-drain lines; a vector table drives whole commands.
module tb_i2c_fsm_master;

   localparam int D = 10;   // CLK_DIV used for the bench

   logic       clk = 1'b0;
   logic       rst_ = 1'b0;
   logic [7:0] cmd = '0;
   logic [7:0] din = '0;
   logic       cmd_valid = 1'b0;
   logic [7:0] dout, status;
   logic       scl_o, scl_oen, sda_o, sda_oen;
   logic       stretch = 1'b0;
   logic       tgt_sda = 1'b1;
   logic       scl_line, sda_line;

   assign scl_line = scl_oen & ~stretch;
   assign sda_line = sda_oen & tgt_sda;

   i2c_fsm_master #(.CLK_DIV(D)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .din       (din),
      .dout      (dout),
      .status    (status),
      .scl_i     (scl_line),
      .scl_o     (scl_o),
      .scl_oen   (scl_oen),
      .sda_i     (sda_line),
      .sda_o     (sda_o),
      .sda_oen   (sda_oen)
   );

   always #5 clk = ~clk;

   // Bus monitor
   int         mon_cnt = 0;
   logic [8:0] mon_cap = '0;
   logic [8:0] mon_snap = '0;   // first 9 bits after a START: byte + ack
   int         stop_cnt = 0;

   always @(negedge sda_line) if (scl_line) begin
      mon_cnt  = 0;
      mon_cap  = '0;
      mon_snap = '0;
   end
   always @(posedge sda_line) if (scl_line) stop_cnt++;
   always @(posedge scl_line) begin
      mon_cap = {mon_cap[7:0], sda_line};
      mon_cnt++;
      if (mon_cnt == 9) mon_snap = mon_cap;
   end

   // Target: drives read data / write ACK while SCL is low
   logic       tgt_read = 1'b0;
   logic       tgt_ack = 1'b1;
   logic [7:0] tgt_byte = '0;
   always @(negedge scl_line) begin
      if (tgt_read && mon_cnt < 8)               tgt_sda = tgt_byte[7 - mon_cnt];
      else if (!tgt_read && tgt_ack && mon_cnt == 8) tgt_sda = 1'b0;
      else                                        tgt_sda = 1'b1;
   end

   // Clock stretch of exactly 300 clk edges in phase B of bit 3
   logic stretch_arm = 1'b0;
   always @(negedge scl_line) if (stretch_arm && mon_cnt == 4) begin
      stretch_arm = 1'b0;
      stretch     = 1'b1;
      wait (scl_oen == 1'b1);
      @(negedge clk);
      repeat (300) @(negedge clk);
      stretch = 1'b0;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Call #1 after a rising edge. Issues one command and waits for done.
   // inject_at > 0 pulses cmd_valid with STOP / din=FF at that cycle while busy.
   task automatic run_cmd(input logic [7:0] c, input logic [7:0] d,
                          input int inject_at, output int cycles);
      stop_cnt  = 0;
      cmd       = c;
      din       = d;
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("busy_after_accept", 32'(status[7]), 32'd1);
      cycles = 0;
      while (status[5] !== 1'b1 && cycles < 20000) begin
         @(posedge clk); #1;
         cycles++;
         cmd_valid = (cycles == inject_at);
         if (cycles == inject_at) begin
            cmd = 8'h40;
            din = 8'hFF;
         end
      end
      cmd_valid = 1'b0;
      check("done_seen", 32'(status[5]), 32'd1);
      check("busy_clear_on_done", 32'(status[7]), 32'd0);
   endtask

   typedef struct {
      logic [7:0] cmd;
      logic [7:0] din;
      logic [7:0] tgt_byte;
      logic       tgt_read;
      logic       tgt_ack;
      logic       chk_cap;
      int         exp_cap;
      int         exp_cycles;
      int         exp_nack;
      int         exp_bus;
      int         exp_dout;
      int         exp_stops;
   } vec_t;

   vec_t vecs[9];
   int   cyc;

   initial begin
      //            cmd    din    tbyte  rd ack chk  cap     cycles  nack bus dout   stops
      vecs[0] = '{8'h90, 8'hA4, 8'h00, 0, 1, 1, 'h148, 40*D,   0,   1,  'h00, 0};
      vecs[1] = '{8'hE8, 8'h00, 8'h5B, 1, 0, 1, 'h0B7, 44*D,   0,   0,  'h5B, 1};
      vecs[2] = '{8'h90, 8'h3C, 8'h00, 0, 0, 1, 'h079, 40*D,   1,   1,  'h5B, 0};
      vecs[3] = '{8'h90, 8'h81, 8'h00, 0, 1, 1, 'h102, 40*D,   0,   1,  'h5B, 0};
      vecs[4] = '{8'h40, 8'h00, 8'h00, 0, 0, 0, 0,      4*D,   0,   0,  'h5B, 1};
      vecs[5] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 0,      1,     0,   0,  'h5B, 0};
      vecs[6] = '{8'hB0, 8'h6E, 8'h00, 0, 1, 1, 'h0DC, 40*D,   0,   1,  'h5B, 0};
      vecs[7] = '{8'hA0, 8'h00, 8'hC5, 1, 0, 1, 'h18A, 40*D,   0,   1,  'hC5, 0};
      vecs[8] = '{8'h50, 8'h09, 8'h00, 0, 0, 0, 0,     40*D,   1,   0,  'hC5, 1};

      // Reset state
      repeat (3) @(posedge clk); #1;
      check("reset_status", 32'(status), 32'h00);
      check("reset_scl_oen", 32'(scl_oen), 32'd1);
      check("reset_sda_oen", 32'(sda_oen), 32'd1);
      check("reset_dout", 32'(dout), 32'h00);
      check("scl_o_tied", 32'(scl_o), 32'd0);
      check("sda_o_tied", 32'(sda_o), 32'd0);
      @(negedge clk) rst_ = 1'b1;
      @(posedge clk); #1;

      // Reset mid-transfer: START phase D, both lines driven by the master
      cmd = 8'h90; din = 8'hA4; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (3*D + 2) @(posedge clk);
      #1;
      check("mid_scl_low", 32'(scl_oen), 32'd0);
      check("mid_bus_busy", 32'(status[0]), 32'd1);
      #2 rst_ = 1'b0;
      #1;
      check("async_rst_scl", 32'(scl_oen), 32'd1);
      check("async_rst_sda", 32'(sda_oen), 32'd1);
      check("async_rst_status", 32'(status), 32'h00);
      @(negedge clk) rst_ = 1'b1;
      repeat (2) @(posedge clk); #1;
      check("post_rst_idle", 32'({status, scl_oen, sda_oen}), 32'h003);

      // Vector table
      for (int i = 0; i < 9; i++) begin
         tgt_read = vecs[i].tgt_read;
         tgt_ack  = vecs[i].tgt_ack;
         tgt_byte = vecs[i].tgt_byte;
         tgt_sda  = 1'b1;
         run_cmd(vecs[i].cmd, vecs[i].din, 0, cyc);
         check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
         check($sformatf("v%0d_nack", i), 32'(status[6]), 32'(vecs[i].exp_nack));
         check($sformatf("v%0d_bus_busy", i), 32'(status[0]), 32'(vecs[i].exp_bus));
         check($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].exp_dout));
         check($sformatf("v%0d_stops", i), 32'(stop_cnt), 32'(vecs[i].exp_stops));
         if (vecs[i].chk_cap)
            check($sformatf("v%0d_sda_bits", i), 32'(mon_snap), 32'(vecs[i].exp_cap));
         @(posedge clk); #1;
         check($sformatf("v%0d_done_one_clk", i), 32'(status[5]), 32'd0);
      end

      // Clock stretch in bit 3 phase B: +300 clks, data intact
      tgt_read = 1'b0; tgt_ack = 1'b1; tgt_sda = 1'b1;
      stretch_arm = 1'b1;
      run_cmd(8'h90, 8'hC3, 0, cyc);
      check("stretch_cycles", 32'(cyc), 32'(40*D + 300));
      check("stretch_sda_bits", 32'(mon_snap), 32'h186);
      check("stretch_nack", 32'(status[6]), 32'd0);
      check("stretch_consumed", 32'(stretch_arm), 32'd0);
      @(posedge clk); #1;

      // cmd_valid while busy is ignored; a command on the done cycle starts at once
      run_cmd(8'h90, 8'h55, 100, cyc);
      check("ign_cycles", 32'(cyc), 32'(40*D));
      check("ign_no_stop", 32'(stop_cnt), 32'd0);
      check("ign_din_kept", 32'(mon_snap), 32'h0AA);
      check("ign_bus_busy", 32'(status[0]), 32'd1);
      run_cmd(8'h40, 8'h00, 0, cyc);
      check("done_cycle_cmd_cycles", 32'(cyc), 32'(4*D));
      check("done_cycle_cmd_stop", 32'(stop_cnt), 32'd1);
      check("done_cycle_cmd_bus", 32'(status[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
